// File: rtl/hitchhike_pkg.sv
// Shared constants and FSM encoding for the backscatter tag transmit path.
package hitchhike_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_t;

    // States in which the payload holding register may accept a word.
    function automatic logic is_active(input tx_state_t s);
        return (s == ST_DELAY) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/trigger_sync.sv
// Two-flop synchronizer for the RF packet-detect line plus rising-edge detect.
module trigger_sync (
    input  logic clock,
    input  logic reset,
    input  logic trigger_signal,
    output logic trig_rise
);

    logic sync_q1;
    logic sync_q2;
    logic sync_prev;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_q1   <= trigger_signal;
            sync_q2   <= sync_q1;
            sync_prev <= sync_q2;
        end
    end

    assign trig_rise = sync_q2 & ~sync_prev;

endmodule

// File: rtl/tag_tx_scheduler.sv
// Tag transmit scheduler: waits a hold-off after a detected packet, then
// shifts payload words out MSB first at a programmable bit rate.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a trigger edge; holding register kept empty
// ST_DELAY | hold-off countdown; first payload word may be loaded
// ST_SHIFT | bits driven on bit_out, RF switch enabled
// ST_DONE  | one-cycle completion pulse
module tag_tx_scheduler
    import hitchhike_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trigger_signal,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic [7:0]        cfg_rate_div,
    input  logic [WORD_W-1:0] data_word,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              bit_out,
    output logic              switch_en,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic              missed_trigger
);

    localparam int WB_W = $clog2(WORD_W + 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic              trig_rise;

    logic [CNT_W-1:0]  tmr;
    logic [CNT_W-1:0]  bits_left;
    logic [7:0]        rate_lat;
    logic [WB_W-1:0]   wbits_left;
    logic [WORD_W-1:0] hold_word;
    logic              hold_valid;
    logic [WORD_W-1:0] shreg;

    logic              ld_cfg;
    logic              tmr_dec;
    logic              tmr_reload;
    logic              ld_word;
    logic              sh_bit;
    logic              bit_adv;
    logic              take_word;

    trigger_sync u_trigger_sync (
        .clock          (clock),
        .reset          (reset),
        .trigger_signal (trigger_signal),
        .trig_rise      (trig_rise)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ld_cfg         = 1'b0;
        tmr_dec        = 1'b0;
        tmr_reload     = 1'b0;
        ld_word        = 1'b0;
        sh_bit         = 1'b0;
        bit_adv        = 1'b0;
        underrun       = 1'b0;
        missed_trigger = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig_rise) begin
                    ld_cfg    = 1'b1;
                    state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                missed_trigger = trig_rise;
                if (tmr != '0) begin
                    tmr_dec = 1'b1;
                end else if (bits_left == '0) begin
                    state_nxt = ST_DONE;
                end else if (hold_valid) begin
                    ld_word    = 1'b1;
                    tmr_reload = 1'b1;
                    state_nxt  = ST_SHIFT;
                end else begin
                    underrun  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                missed_trigger = trig_rise;
                if (tmr != '0) begin
                    tmr_dec = 1'b1;
                end else begin
                    // End of a bit period: finish, refill at a word boundary, or shift.
                    bit_adv = 1'b1;
                    if (bits_left == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end else if (wbits_left == WB_W'(1)) begin
                        if (hold_valid) begin
                            ld_word    = 1'b1;
                            tmr_reload = 1'b1;
                        end else begin
                            underrun  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        sh_bit     = 1'b1;
                        tmr_reload = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                missed_trigger = trig_rise;
                state_nxt      = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state != ST_IDLE);
    assign switch_en  = (state == ST_SHIFT);
    assign bit_out    = switch_en & shreg[WORD_W-1];
    assign done       = (state == ST_DONE);
    assign data_ready = is_active(state) & ~hold_valid;
    assign take_word  = data_valid & data_ready;

    // One shared down-counter times the hold-off, then each bit period.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmr       <= '0;
            bits_left <= '0;
            rate_lat  <= '0;
        end else begin
            if (ld_cfg) begin
                tmr       <= cfg_delay;
                bits_left <= cfg_len;
                rate_lat  <= cfg_rate_div;
            end else begin
                if (tmr_reload) begin
                    tmr <= CNT_W'(rate_lat);
                end else if (tmr_dec) begin
                    tmr <= tmr - CNT_W'(1);
                end
                if (bit_adv) begin
                    bits_left <= bits_left - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_word  <= '0;
            hold_valid <= 1'b0;
        end else if (state == ST_IDLE) begin
            hold_word  <= '0;
            hold_valid <= 1'b0;
        end else if (take_word) begin
            hold_word  <= data_word;
            hold_valid <= 1'b1;
        end else if (ld_word) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shreg      <= '0;
            wbits_left <= '0;
        end else if (ld_word) begin
            shreg      <= hold_word;
            wbits_left <= WB_W'(WORD_W);
        end else if (sh_bit) begin
            shreg      <= shreg << 1;
            wbits_left <= wbits_left - WB_W'(1);
        end
    end

endmodule

// File: tb/tb_tag_tx_scheduler.sv
// Self-checking bench for tag_tx_scheduler: directed vector table, reset
// corner sequences and randomized packets against a cycle-position model.
module tb_tag_tx_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        trigger_signal;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_len;
    logic [7:0]  cfg_rate_div;
    logic [15:0] data_word;
    logic        data_valid;
    logic        data_ready;
    logic        bit_out;
    logic        switch_en;
    logic        busy;
    logic        done;
    logic        underrun;
    logic        missed_trigger;

    int errors = 0;
    int checks = 0;

    int          m_on;
    int          m_done;
    int          m_und;
    int          m_busy;
    int          m_missed;
    logic [63:0] m_stream;

    tag_tx_scheduler #(.WORD_W(16), .CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .trigger_signal (trigger_signal),
        .cfg_delay      (cfg_delay),
        .cfg_len        (cfg_len),
        .cfg_rate_div   (cfg_rate_div),
        .data_word      (data_word),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .bit_out        (bit_out),
        .switch_en      (switch_en),
        .busy           (busy),
        .done           (done),
        .underrun       (underrun),
        .missed_trigger (missed_trigger)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          d;
        int          len;
        int          rate;
        int          nw;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          retrig;
        int          exp_on;
        logic [63:0] exp_stream;
        int          exp_done;
        int          exp_und;
        int          exp_busy;
        int          exp_missed;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle index (posedges counted from the one that first samples the
    // trigger high) of the last cycle in which the scheduler is busy.
    function automatic int model_last(input int d, input int len, input int rate, input int nw);
        int s;
        s = d + 4;
        if (len > 0 && 16 * nw < len) return s + 16 * nw * (rate + 1) - 1;
        return s + len * (rate + 1);
    endfunction

    // Producer offers nw words back to back; optional retrigger at cycle retrig.
    task automatic run_case(input int d, input int len, input int rate, input int nw,
                            input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input int retrig);
        logic [15:0] words [3];
        int   p, s, last, nbits, widx, idx;
        bit   und, sw_e, busy_e;
        logic bit_e, hs;
        logic [5:0] act, expv;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        p     = rate + 1;
        s     = d + 4;
        und   = (len > 0) && (16 * nw < len);
        nbits = und ? 16 * nw : len;
        last  = model_last(d, len, rate, nw);
        widx  = 0;
        m_on = 0; m_done = 0; m_und = 0; m_busy = 0; m_missed = 0; m_stream = '0;
        @(negedge clock);
        cfg_delay    = 16'(d);
        cfg_len      = 16'(len);
        cfg_rate_div = 8'(rate);
        for (int k = 1; k <= last + 4; k++) begin
            trigger_signal = (k <= 2) || (retrig != 0 && (k == retrig || k == retrig + 1));
            if (k >= 4) begin
                cfg_delay    = 16'($urandom);
                cfg_len      = 16'($urandom);
                cfg_rate_div = 8'($urandom);
            end
            data_valid = (widx < nw);
            data_word  = (widx < nw) ? words[widx] : 16'h0000;
            #1;
            hs = data_valid & data_ready;
            @(posedge clock);
            if (hs) widx++;
            #1;
            busy_e = (k >= 3) && (k <= last);
            sw_e   = (k >= s) && (k < s + nbits * p);
            bit_e  = 1'b0;
            if (sw_e) begin
                idx   = (k - s) / p;
                bit_e = words[idx / 16][15 - (idx % 16)];
            end
            expv = {busy_e, sw_e, bit_e, (!und && k == last), (und && k == last),
                    (retrig != 0 && k == retrig + 1)};
            act  = {busy, switch_en, bit_out, done, underrun, missed_trigger};
            check($sformatf("cyc%0d d%0d l%0d r%0d n%0d", k, d, len, rate, nw), 64'(act), 64'(expv));
            if (switch_en) begin
                m_on++;
                m_stream = {m_stream[62:0], bit_out};
            end
            if (done) m_done++;
            if (underrun) m_und++;
            if (busy) m_busy++;
            if (missed_trigger) m_missed++;
            @(negedge clock);
        end
        trigger_signal = 1'b0;
        data_valid     = 1'b0;
    endtask

    initial begin
        int d, len, rate, nw, last, retrig;
        logic [15:0] w0, w1, w2;

        //            d  len r  n  w0        w1        w2  re  on  stream          dn un busy miss
        tbl[0] = '{5, 16, 0, 1, 16'hA5C3, 16'h0000, 16'h0, 0, 16, 64'hA5C3,     1, 0, 23, 0};
        tbl[1] = '{2, 4,  3, 1, 16'h9000, 16'h0000, 16'h0, 0, 16, 64'hF00F,     1, 0, 20, 0};
        tbl[2] = '{5, 40, 0, 2, 16'h1234, 16'hBEEF, 16'h0, 0, 32, 64'h1234BEEF, 0, 1, 38, 0};
        tbl[3] = '{3, 16, 1, 1, 16'h5A96, 16'h0000, 16'h0, 12, 32, 64'h33CCC33C, 1, 0, 37, 1};
        tbl[4] = '{7, 0,  2, 1, 16'hFFFF, 16'h0000, 16'h0, 0, 0,  64'h0,        1, 0, 9,  0};
        tbl[5] = '{1, 20, 0, 2, 16'hF0F0, 16'h8000, 16'h0, 0, 20, 64'hF0F08,    1, 0, 23, 0};
        tbl[6] = '{4, 16, 0, 0, 16'h0000, 16'h0000, 16'h0, 0, 0,  64'h0,        0, 1, 5,  0};
        tbl[7] = '{2, 3,  1, 1, 16'h6000, 16'h0000, 16'h0, 0, 6,  64'h0F,       1, 0, 10, 0};

        reset = 1'b0; trigger_signal = 1'b0; data_valid = 1'b0; data_word = '0;
        cfg_delay = '0; cfg_len = '0; cfg_rate_div = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset outputs",
              64'({data_ready, bit_out, switch_en, busy, done, underrun, missed_trigger}), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_case(tbl[i].d, tbl[i].len, tbl[i].rate, tbl[i].nw,
                     tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].retrig);
            check($sformatf("v%0d switch_en cycles", i), 64'(m_on), 64'(tbl[i].exp_on));
            check($sformatf("v%0d bitstream", i), m_stream, tbl[i].exp_stream);
            check($sformatf("v%0d done pulses", i), 64'(m_done), 64'(tbl[i].exp_done));
            check($sformatf("v%0d underrun pulses", i), 64'(m_und), 64'(tbl[i].exp_und));
            check($sformatf("v%0d busy cycles", i), 64'(m_busy), 64'(tbl[i].exp_busy));
            check($sformatf("v%0d missed pulses", i), 64'(m_missed), 64'(tbl[i].exp_missed));
        end

        // Reset asserted in the middle of a shifting packet.
        @(negedge clock);
        cfg_delay = 16'd2; cfg_len = 16'd32; cfg_rate_div = 8'd0;
        data_word = 16'hFFFF; data_valid = 1'b1; trigger_signal = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 2) trigger_signal = 1'b0;
        end
        check("pre-reset shifting", 64'({switch_en, bit_out}), 64'd3);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("mid-shift reset outputs",
              64'({data_ready, bit_out, switch_en, busy, done, underrun, missed_trigger}), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        data_valid = 1'b0;
        run_case(5, 16, 0, 1, 16'hA5C3, 16'h0000, 16'h0000, 0);
        check("post-reset bitstream", m_stream, 64'hA5C3);
        check("post-reset switch_en cycles", 64'(m_on), 64'd16);
        check("post-reset done pulses", 64'(m_done), 64'd1);

        for (int i = 0; i < 30; i++) begin
            d    = $urandom_range(1, 10);
            len  = $urandom_range(0, 48);
            rate = $urandom_range(0, 3);
            nw   = $urandom_range(0, 3);
            w0   = 16'($urandom);
            w1   = 16'($urandom);
            w2   = 16'($urandom);
            last = model_last(d, len, rate, nw);
            retrig = 0;
            if ($urandom_range(0, 1) == 1 && last - 1 >= 5) retrig = $urandom_range(5, last - 1);
            run_case(d, len, rate, nw, w0, w1, w2, retrig);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tag_tx_scheduler.md
TAG_TX_SCHEDULER -- requirements
Module: tag_tx_scheduler

Interface
REQ-001 SHALL have parameter WORD_W, default 16, payload word width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of delay and bit-length counters.
REQ-003 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port trigger_signal  in  1  asynchronous packet-detect from the RF front end.
REQ-006 SHALL have port cfg_delay  in  CNT_W  number of hold-off cycles between trigger and first bit.
REQ-007 SHALL have port cfg_len  in  CNT_W  number of payload bits per packet.
REQ-008 SHALL have port cfg_rate_div  in  8  clocks per bit minus one.
REQ-009 SHALL have port data_word / data_valid / data_ready  in/in/out  WORD_W/1/1  payload word handshake.
REQ-010 SHALL have port bit_out  out  1  current tag bit to the codeword-translation switch driver.
REQ-011 SHALL have port switch_en  out  1  RF switch modulation enable.
REQ-012 SHALL have ports busy, done, underrun, missed_trigger  out  1 each  status; done/underrun/missed_trigger are one-cycle pulses.

Function
REQ-013 SHALL pass trigger_signal through a 2-flop synchronizer and detect its rising edge; the FSM leaves IDLE on the 3rd rising clock edge after trigger_signal is first sampled high.
REQ-014 SHALL latch cfg_delay, cfg_len and cfg_rate_div on trigger acceptance; later config changes SHALL NOT affect the packet in flight.
REQ-015 SHALL implement states IDLE, DELAY, SHIFT, DONE; IDLE->DELAY on trigger edge; DELAY->SHIFT after exactly cfg_delay+1 cycles in DELAY; SHIFT->DONE after the last bit period; DONE->IDLE after one cycle.
REQ-016 SHALL go IDLE->DELAY->DONE, never asserting switch_en, when latched cfg_len = 0.
REQ-017 SHALL keep a one-word holding register; data_ready = 1 while state is DELAY or SHIFT and holding register is empty; a word is taken on the cycle data_valid & data_ready.
REQ-018 SHALL, at each word boundary (SHIFT entry and every WORD_W bits), move the holding word into the shift register; bits shifted MSB first.
REQ-019 SHALL hold each bit on bit_out for exactly cfg_rate_div+1 cycles; cfg_rate_div = 0 gives one bit per clock with no gaps between bits or words.
REQ-020 SHALL assert switch_en throughout SHIFT and deassert it on the cycle SHIFT is exited.
REQ-021 SHALL, if the holding register is empty at a word boundary, pulse underrun, drive switch_en = 0 and bit_out = 0 next cycle, and return to IDLE without done.
REQ-022 SHALL, when cfg_len is not a multiple of WORD_W, discard the unused low bits of the final word.
REQ-023 SHALL pulse done for one cycle in DONE; busy = 1 in every state except IDLE.
REQ-024 SHALL ignore trigger edges outside IDLE and pulse missed_trigger once per ignored edge.
REQ-025 SHALL clear the holding register on return to IDLE.

Reset
REQ-026 SHALL, on reset low at a clock edge, enter IDLE and drive bit_out, switch_en, busy, done, underrun, missed_trigger, data_ready to 0 on the following cycle, including mid-packet.
REQ-027 SHALL clear synchronizer flops, counters, holding and shift registers on reset.

Structure
REQ-028 SHALL take the state encoding and default WORD_W/CNT_W constants from shared package hitchhike_pkg.
REQ-029 SHALL place synchronizer plus edge detect in sub-module trigger_sync.

Verification
REQ-030 SHALL test cfg_delay=5, cfg_len=16, cfg_rate_div=0, word 0xA5C3 preloaded -> switch_en high 16 cycles, bit_out 1010010111000011, done pulse once.
REQ-031 SHALL test cfg_rate_div=3, cfg_len=4, word 0x9000 -> bit_out 1,0,0,1 each held 4 cycles, switch_en high 16 cycles.
REQ-032 SHALL test cfg_len=40 with only two words supplied -> underrun pulse at bit 32, switch_en low next cycle, no done.
REQ-033 SHALL test a second trigger during SHIFT -> one missed_trigger pulse, bitstream unchanged.
REQ-034 SHALL test cfg_len=0 -> busy for cfg_delay+2 cycles, done pulse, switch_en never high.
REQ-035 SHALL test reset low mid-SHIFT -> all outputs 0 next cycle, new trigger then runs a normal packet.
